// File: rtl/maze_cmd_seq.sv
// maze_cmd_seq: command sequencer between the UART command wrapper and the
// PID line-follower datapath. Dispatches CAL/MOVE/STOP commands, counts line
// segment ends, bridges gaps between segments and reports one response byte
// per command.
module maze_cmd_seq #(
    parameter int unsigned LOST_CYC = 16,
    parameter int unsigned MAX_GAP  = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    input  logic        line_present,
    input  logic        cal_done,
    output logic        strt_cal,
    output logic        in_cal,
    output logic        go,
    output logic        busy,
    output logic        send_resp,
    output logic [7:0]  resp
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAL,
        ST_MOVE,
        ST_GAP
    } state_e;

    typedef enum logic [1:0] {
        OP_CAL  = 2'b00,
        OP_MOVE = 2'b01,
        OP_STOP = 2'b10,
        OP_ILL  = 2'b11
    } op_e;

    localparam logic [7:0]  RESP_DONE = 8'hA5;
    localparam logic [7:0]  RESP_STOP = 8'h5A;
    localparam logic [7:0]  RESP_ERR  = 8'hEE;
    localparam logic [15:0] LOST_LIM  = 16'(LOST_CYC);
    localparam logic [15:0] GAP_LIM   = 16'(MAX_GAP);

    state_e      state_q, state_d;
    logic [7:0]  seg_cnt_q, seg_cnt_d;
    logic [15:0] lost_cnt_q, lost_cnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic        clr_q, clr_d;
    logic        strt_q, strt_d;
    logic        in_cal_q, in_cal_d;
    logic        go_q, go_d;
    logic        busy_q, busy_d;
    logic        send_q, send_d;
    logic [7:0]  resp_q, resp_d;

    op_e         op;
    logic        cmd_take;
    logic        stop_req;
    logic [15:0] lost_inc;
    logic [15:0] gap_inc;
    logic        seg_end;
    logic        cmd_unused;

    // Bits [13:8] of the command word carry no meaning for this block.
    assign cmd_unused = ^cmd[13:8];

    // Command decode and saturating counter increments.
    always_comb begin
        op       = op_e'(cmd[15:14]);
        // A raised clr_cmd_rdy means the pending word was already taken.
        cmd_take = cmd_rdy && !clr_q;
        stop_req = cmd_take && (op == OP_STOP);
        lost_inc = (lost_cnt_q == LOST_LIM) ? lost_cnt_q : lost_cnt_q + 16'd1;
        gap_inc  = (gap_cnt_q == GAP_LIM) ? gap_cnt_q : gap_cnt_q + 16'd1;
        // Fires only on the LOST_CYC-th consecutive low, never again while saturated.
        seg_end  = !line_present && (lost_cnt_q != LOST_LIM) && (lost_inc == LOST_LIM);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        seg_cnt_d  = seg_cnt_q;
        lost_cnt_d = lost_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        clr_d      = 1'b0;
        strt_d     = 1'b0;
        in_cal_d   = in_cal_q;
        go_d       = go_q;
        send_d     = 1'b0;
        resp_d     = resp_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_take) begin
                    clr_d = 1'b1;
                    unique case (op)
                        OP_CAL: begin
                            state_d  = ST_CAL;
                            strt_d   = 1'b1;
                            in_cal_d = 1'b1;
                        end
                        OP_MOVE: begin
                            if (cmd[7:0] == 8'd0) begin
                                send_d = 1'b1;
                                resp_d = RESP_DONE;
                            end else begin
                                state_d    = ST_MOVE;
                                seg_cnt_d  = cmd[7:0];
                                lost_cnt_d = '0;
                                go_d       = 1'b1;
                            end
                        end
                        OP_STOP: begin
                            send_d = 1'b1;
                            resp_d = RESP_STOP;
                        end
                        OP_ILL: begin
                            send_d = 1'b1;
                            resp_d = RESP_ERR;
                        end
                        default: ;
                    endcase
                end
            end

            ST_CAL: begin
                // strt_q is high exactly on the entry cycle; cal_done is ignored there.
                if (cal_done && !strt_q) begin
                    state_d  = ST_IDLE;
                    in_cal_d = 1'b0;
                    send_d   = 1'b1;
                    resp_d   = RESP_DONE;
                end
            end

            ST_MOVE: begin
                if (stop_req) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                    go_d    = 1'b0;
                    send_d  = 1'b1;
                    resp_d  = RESP_STOP;
                end else if (line_present) begin
                    lost_cnt_d = '0;
                end else begin
                    lost_cnt_d = lost_inc;
                    if (seg_end) begin
                        if (seg_cnt_q <= 8'd1) begin
                            seg_cnt_d = '0;
                            state_d   = ST_IDLE;
                            go_d      = 1'b0;
                            send_d    = 1'b1;
                            resp_d    = RESP_DONE;
                        end else begin
                            seg_cnt_d = seg_cnt_q - 8'd1;
                            state_d   = ST_GAP;
                            gap_cnt_d = '0;
                        end
                    end
                end
            end

            ST_GAP: begin
                if (stop_req) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                    go_d    = 1'b0;
                    send_d  = 1'b1;
                    resp_d  = RESP_STOP;
                end else if (line_present) begin
                    // Re-acquire is checked before the timeout so it wins a tie.
                    state_d    = ST_MOVE;
                    lost_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_inc;
                    if (gap_inc == GAP_LIM) begin
                        state_d = ST_IDLE;
                        go_d    = 1'b0;
                        send_d  = 1'b1;
                        resp_d  = RESP_ERR;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                go_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, counter and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            seg_cnt_q  <= '0;
            lost_cnt_q <= '0;
            gap_cnt_q  <= '0;
            clr_q      <= 1'b0;
            strt_q     <= 1'b0;
            in_cal_q   <= 1'b0;
            go_q       <= 1'b0;
            busy_q     <= 1'b0;
            send_q     <= 1'b0;
            resp_q     <= '0;
        end else begin
            state_q    <= state_d;
            seg_cnt_q  <= seg_cnt_d;
            lost_cnt_q <= lost_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            clr_q      <= clr_d;
            strt_q     <= strt_d;
            in_cal_q   <= in_cal_d;
            go_q       <= go_d;
            busy_q     <= busy_d;
            send_q     <= send_d;
            resp_q     <= resp_d;
        end
    end

    assign clr_cmd_rdy = clr_q;
    assign strt_cal    = strt_q;
    assign in_cal      = in_cal_q;
    assign go          = go_q;
    assign busy        = busy_q;
    assign send_resp   = send_q;
    assign resp        = resp_q;

endmodule

// File: tb/tb_maze_cmd_seq.sv
// Testbench for maze_cmd_seq: directed and randomized command traffic with
// line_present patterns built from high/low run lengths; expected responses
// and their timing are derived from the run lengths.
module tb_maze_cmd_seq;

    localparam int unsigned LOST = 16;
    localparam int unsigned GAPM = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cmd = '0;
    logic        cmd_rdy = 1'b0;
    logic        line_present = 1'b1;
    logic        cal_done = 1'b0;
    logic        clr_cmd_rdy, strt_cal, in_cal, go, busy, send_resp;
    logic [7:0]  resp;

    int n_checks = 0;
    int n_fail   = 0;

    maze_cmd_seq #(
        .LOST_CYC(LOST),
        .MAX_GAP (GAPM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .line_present(line_present),
        .cal_done    (cal_done),
        .strt_cal    (strt_cal),
        .in_cal      (in_cal),
        .go          (go),
        .busy        (busy),
        .send_resp   (send_resp),
        .resp        (resp)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Immediate-response command; cmd_rdy is held one extra cycle to show it is not re-consumed.
    task automatic issue_imm(input logic [15:0] c, input logic [7:0] er);
        cmd = c;
        cmd_rdy = 1'b1;
        tick;
        check_eq("imm_clr", clr_cmd_rdy, 1);
        check_eq("imm_send", send_resp, 1);
        check_eq("imm_resp", resp, er);
        check_eq("imm_go", go, 0);
        check_eq("imm_busy", busy, 0);
        tick;
        check_eq("imm_clr_once", clr_cmd_rdy, 0);
        check_eq("imm_send_once", send_resp, 0);
        cmd_rdy = 1'b0;
        tick;
        check_eq("imm_idle_send", send_resp, 0);
        check_eq("imm_resp_hold", resp, er);
    endtask

    // Remainder of a calibration after the dispatch cycle has been observed.
    task automatic finish_cal(input bit entry_done);
        int d;
        cal_done = entry_done;
        tick;
        cal_done = 1'b0;
        check_eq("cal_inc", in_cal, 1);
        check_eq("cal_strt_pulse", strt_cal, 0);
        check_eq("cal_clr_pulse", clr_cmd_rdy, 0);
        d = $urandom_range(0, 4);
        for (int k = 0; k < d; k++) begin
            tick;
            check_eq("cal_wait_inc", in_cal, 1);
            check_eq("cal_wait_send", send_resp, 0);
        end
        cal_done = 1'b1;
        tick;
        cal_done = 1'b0;
        check_eq("cal_end_inc", in_cal, 0);
        check_eq("cal_end_send", send_resp, 1);
        check_eq("cal_end_resp", resp, 8'hA5);
        check_eq("cal_end_busy", busy, 0);
        tick;
        check_eq("cal_after_send", send_resp, 0);
    endtask

    task automatic do_cal(input bit entry_done);
        cmd = 16'h0000;
        cmd_rdy = 1'b1;
        tick;
        check_eq("cal_clr", clr_cmd_rdy, 1);
        check_eq("cal_strt", strt_cal, 1);
        check_eq("cal_in", in_cal, 1);
        check_eq("cal_busy", busy, 1);
        check_eq("cal_send", send_resp, 0);
        cmd_rdy = 1'b0;
        finish_cal(entry_done);
    endtask

    // mode 0: plain move, 1: STOP injected, 2: CAL left pending during the move.
    // directed 0: random runs, 1: 20-low gap then 16-low end, 2: line held low.
    task automatic run_move(input int cnt, input int mode, input int directed);
        bit   lp[$];
        int   runs[$];
        int   ev, segs, idx, k, h, l, sel, s, c, se;
        logic [7:0] er;
        if (directed == 1) runs = '{3, 20, 2, 16};
        else if (directed == 2) runs = '{2, 300};
        else runs = '{};
        ev = -1;
        er = 8'h00;
        segs = cnt;
        idx = 0;
        k = 0;
        while (ev < 0) begin
            if (2 * k + 1 < runs.size()) begin
                h = runs[2 * k];
                l = runs[2 * k + 1];
            end else begin
                h = $urandom_range(1, 6);
                sel = $urandom_range(0, 11);
                if (sel < 3) l = $urandom_range(1, LOST - 1);
                else if (sel == 3) l = LOST - 1;
                else if (sel == 4) l = LOST;
                else if (sel == 5) l = LOST + GAPM - 1;
                else if (sel == 6) l = LOST + GAPM;
                else if (sel < 11) l = $urandom_range(LOST, LOST + 30);
                else l = LOST + GAPM + $urandom_range(1, 5);
            end
            k++;
            for (int j = 0; j < h; j++) lp.push_back(1'b1);
            for (int j = 0; j < l; j++) lp.push_back(1'b0);
            idx += h;
            if (l >= LOST) begin
                se = idx + LOST - 1;
                segs--;
                if (segs == 0) begin
                    ev = se;
                    er = 8'hA5;
                end else if (l - LOST >= GAPM) begin
                    ev = se + GAPM;
                    er = 8'hEE;
                end
            end
            idx += l;
        end
        s = -1;
        c = -1;
        if (mode == 1) begin
            s = ($urandom_range(0, 2) == 0) ? ev : $urandom_range(0, ev);
            ev = s;
            er = 8'h5A;
        end else if (mode == 2) begin
            c = $urandom_range(0, ev);
        end

        cmd = 16'h4000 | 16'(cnt);
        cmd_rdy = 1'b1;
        tick;
        check_eq("mv_clr", clr_cmd_rdy, 1);
        check_eq("mv_go_on", go, 1);
        check_eq("mv_busy", busy, 1);
        check_eq("mv_send", send_resp, 0);
        cmd_rdy = 1'b0;
        for (int i = 0; i <= ev; i++) begin
            line_present = (i < lp.size()) ? lp[i] : 1'b1;
            if (i == s) begin
                cmd = 16'h8000;
                cmd_rdy = 1'b1;
            end
            if (i == c) begin
                cmd = 16'h0000;
                cmd_rdy = 1'b1;
            end
            tick;
            if (i == s) begin
                check_eq("mv_stop_clr", clr_cmd_rdy, 1);
                cmd_rdy = 1'b0;
            end else begin
                check_eq("mv_no_clr", clr_cmd_rdy, 0);
            end
            if (i == ev) begin
                check_eq("mv_end_go", go, 0);
                check_eq("mv_end_send", send_resp, 1);
                check_eq("mv_end_resp", resp, er);
                check_eq("mv_end_busy", busy, 0);
            end else begin
                check_eq("mv_go", go, 1);
                check_eq("mv_nosend", send_resp, 0);
                check_eq("mv_busy_on", busy, 1);
            end
        end
        line_present = 1'b1;
        if (mode == 2) begin
            tick;
            check_eq("pend_cal_clr", clr_cmd_rdy, 1);
            check_eq("pend_cal_strt", strt_cal, 1);
            check_eq("pend_cal_in", in_cal, 1);
            check_eq("pend_cal_send", send_resp, 0);
            cmd_rdy = 1'b0;
            finish_cal(1'b0);
        end else begin
            tick;
            check_eq("mv_single_resp", send_resp, 0);
            check_eq("mv_go_stays_off", go, 0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, mode;
        repeat (2) tick;
        check_eq("rst_go", go, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_resp", resp, 8'h00);
        check_eq("rst_clr", clr_cmd_rdy, 0);
        check_eq("rst_send", send_resp, 0);
        check_eq("rst_strt", strt_cal, 0);
        check_eq("rst_incal", in_cal, 0);
        rst_n = 1'b1;
        tick;
        check_eq("idle_busy", busy, 0);

        do_cal(1'b0);
        do_cal(1'b1);
        run_move(2, 0, 1);
        run_move(3, 0, 2);
        run_move(5, 1, 0);
        issue_imm(16'hC000, 8'hEE);
        issue_imm(16'h4000, 8'hA5);
        issue_imm(16'h8000, 8'h5A);
        run_move(1, 2, 0);

        for (int it = 0; it < 30; it++) begin
            cnt = $urandom_range(1, 4);
            mode = $urandom_range(0, 2);
            run_move(cnt, mode, 0);
            case ($urandom_range(0, 3))
                0: issue_imm(16'hC000 | 16'($urandom_range(0, 255)), 8'hEE);
                1: issue_imm(16'h4000, 8'hA5);
                2: issue_imm(16'h8000, 8'h5A);
                default: do_cal(1'($urandom_range(0, 1)));
            endcase
        end

        // Reset in the middle of a move.
        cmd = 16'h4003;
        cmd_rdy = 1'b1;
        tick;
        cmd_rdy = 1'b0;
        line_present = 1'b0;
        repeat (5) tick;
        check_eq("prerst_go", go, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_go", go, 0);
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_send", send_resp, 0);
        check_eq("async_rst_resp", resp, 8'h00);
        tick;
        check_eq("rst_hold_send", send_resp, 0);
        rst_n = 1'b1;
        line_present = 1'b1;
        tick;
        check_eq("post_rst_go", go, 0);
        check_eq("post_rst_send", send_resp, 0);
        issue_imm(16'h8000, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/maze_cmd_seq.md
# maze_cmd_seq

Command sequencer that sits between the UART command wrapper and the PID line-follower datapath of the maze runner. It accepts 16-bit commands over a cmd_rdy/clr_cmd_rdy handshake, sequences IR calibration, and gates the PID `go` input for a commanded number of line segments. It monitors `line_present` to count segment ends and bridge gaps, and returns an 8-bit response per command.

## Interface
- LOST_CYC, 16, consecutive `line_present`=0 cycles that mark a segment end (1..65535)
- MAX_GAP, 4096, cycles allowed to re-acquire the line before aborting (1..65535)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd  in  16  command word; [15:14] opcode, [7:0] segment count (MOVE)
- cmd_rdy  in  1  level: valid command pending from UART wrapper
- clr_cmd_rdy  out  1  one-cycle pulse: command consumed
- line_present  in  1  IR sensors see the line
- cal_done  in  1  one-cycle pulse from IR calibration logic
- strt_cal  out  1  one-cycle pulse: start calibration
- in_cal  out  1  level: calibration in progress
- go  out  1  level: enables the PID block / forward ramp
- busy  out  1  level: state ≠ IDLE
- send_resp  out  1  one-cycle pulse: `resp` valid
- resp  out  8  response code; holds until next `send_resp`

## Operation
- Opcodes: 00 CAL, 01 MOVE, 10 STOP, 11 illegal.
- Responses: 0xA5 = done, 0x5A = stopped, 0xEE = error/abort.
- States: IDLE, CAL, MOVE, GAP.
- IDLE: on `cmd_rdy`=1, latch cmd, pulse `clr_cmd_rdy` next cycle and dispatch:
  - CAL → CAL state.
  - MOVE with count 0 → `send_resp` 0xA5, stay IDLE, `go` never asserted.
  - MOVE with count ≠ 0 → seg_cnt=count, MOVE state.
  - STOP → 0x5A, stay IDLE.
  - 11 → 0xEE, stay IDLE.
- CAL: `strt_cal` pulses on the entry cycle; `in_cal`=1 for the whole state. On `cal_done` → `in_cal`=0, 0xA5, IDLE. `cal_done` is ignored on the entry cycle. Commands are not consumed in CAL.
- MOVE: `go`=1. lost_cnt (16 b) increments on each `line_present`=0 and clears on `line_present`=1. When lost_cnt reaches LOST_CYC, seg_cnt decrements:
  - seg_cnt becomes 0 → `go`=0, 0xA5, IDLE.
  - otherwise → GAP with gap_cnt=0.
- GAP: `go` stays 1; gap_cnt increments each cycle.
  - `line_present`=1 → MOVE with lost_cnt=0.
  - gap_cnt reaches MAX_GAP → `go`=0, 0xEE, IDLE.
- MOVE/GAP, `cmd_rdy` with opcode STOP → pulse `clr_cmd_rdy`, `go`=0, 0x5A, IDLE.
- Any other opcode while busy is left pending: `cmd_rdy` is not cleared and is dispatched once back in IDLE.
- Simultaneous events:
  - STOP and segment-end/gap-timeout on the same cycle → STOP wins; single response 0x5A.
  - GAP re-acquire and gap timeout on the same cycle → re-acquire wins.
- Counters never wrap: lost_cnt saturates at LOST_CYC; seg_cnt never decrements below 0.
- Reset mid-operation: all state is lost immediately; `go` drops asynchronously. No response is sent.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `go`=0, `in_cal`=0, `strt_cal`=0, `clr_cmd_rdy`=0, `send_resp`=0, `busy`=0, `resp`=0x00, all counters 0.
- Command latency: `cmd_rdy` sampled at edge N; at N+1 `clr_cmd_rdy`=1, new state entered, and `go`/`strt_cal`/`in_cal`/`busy` take their new values. Immediate responses (`send_resp`) also appear at N+1.
- The wrapper drops `cmd_rdy` by N+2. Dispatch is gated by `clr_cmd_rdy`=0, so one command is never consumed twice.
- Segment end: the LOST_CYC-th consecutive low `line_present` sampled at edge M gives the state/`go` change and any `send_resp` at M+1.
- `send_resp` and the final `go` fall occur on the same cycle.
- `cal_done` at edge K gives `in_cal`=0 and `send_resp` at K+1.

## Test plan
- Reset, then CAL (cmd=0x0000): `clr_cmd_rdy` and `strt_cal` pulse 1 cycle after `cmd_rdy`; `in_cal` high until 1 cycle after `cal_done`; resp=0xA5.
- MOVE count 2 (cmd=0x4002), LOST_CYC=16, gap of 20 low cycles re-acquired after 4 more, then a second 16-cycle loss: `go` high throughout the first gap; `go` falls and resp=0xA5 exactly 1 cycle after the 16th low of the second loss.
- MOVE 0x4003, `line_present` held low with MAX_GAP=100: after the first segment end, gap times out at 100 cycles → `go`=0, resp=0xEE.
- MOVE 0x4005, then STOP (0x8000) mid-segment: `clr_cmd_rdy` pulses, `go`=0, resp=0x5A next cycle. Repeat with STOP landing on the segment-end cycle → a single 0x5A.
- CAL issued while MOVE is busy: `cmd_rdy` is not cleared until the move completes (0xA5), then CAL dispatches.
- Illegal opcode 0xC000 → 0xEE. MOVE 0x4000 → 0xA5 with `go` never high. Assert `rst_n` low during MOVE → `go`=0 asynchronously, no `send_resp`.
